// File: rtl/s2_kes_dcme_param_pkg.sv
// Shared definitions for the RS stage-2 key-equation solver: symbol width,
// field polynomial, bus slicing helpers and the GF(2^8) multiply.
package s2_kes_dcme_param_pkg;

    localparam int unsigned SW        = 8;
    localparam logic [8:0]  PRIM_POLY = 9'h11D;
    localparam int unsigned MAX_T     = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ITER,
        ST_FIN
    } kes_state_e;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_SHIFT,
        OP_COMPUTE
    } kes_op_e;

    function automatic int unsigned syn_idx(input int unsigned i);
        return i * SW;
    endfunction

    function automatic int unsigned coef_idx(input int unsigned j);
        return j * SW;
    endfunction

    // Shift-and-add multiply, reducing by the field polynomial after each shift.
    function automatic logic [SW-1:0] gf_mul(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [SW-1:0] acc;
        logic [SW-1:0] sh;
        acc = '0;
        sh  = a;
        for (int unsigned i = 0; i < SW; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[SW-2:0], 1'b0} ^ (sh[SW-1] ? PRIM_POLY[SW-1:0] : '0);
        end
        return acc;
    endfunction

endpackage

// File: rtl/s2_kes_dcme_param_if.sv
// Start/syndrome inputs and locator/evaluator/status outputs of the KES stage.
interface s2_kes_dcme_param_if #(
    parameter int unsigned T = 2
);
    import s2_kes_dcme_param_pkg::*;

    logic                  kes_ena;
    logic [SW*2*T-1:0]     rs_syn;
    logic [SW*(T+1)-1:0]   rs_lambda;
    logic [SW*T-1:0]       rs_omega;
    logic                  kes_busy;
    logic                  kes_done;
    logic                  kes_fail;

    modport master (
        output kes_ena, rs_syn,
        input  rs_lambda, rs_omega, kes_busy, kes_done, kes_fail
    );

    modport slave (
        input  kes_ena, rs_syn,
        output rs_lambda, rs_omega, kes_busy, kes_done, kes_fail
    );

endinterface

// File: rtl/s2_kes_dcme_param_pe.sv
// One word slice (k >= 1) of the DCME R/Q datapath, plus the GF(2^8) multiplier
// it is built from.
module s2_kes_dcme_param_pe
    import s2_kes_dcme_param_pkg::*;
(
    input  kes_op_e         op_i,
    input  logic            swap_i,
    input  logic [SW-1:0]   msb_r_i,
    input  logic [SW-1:0]   msb_q_i,
    input  logic [SW-1:0]   r_prev_i,
    input  logic [SW-1:0]   q_prev_i,
    input  logic [SW-1:0]   r_cur_i,
    input  logic [SW-1:0]   q_cur_i,
    output logic [SW-1:0]   r_nxt_o,
    output logic [SW-1:0]   q_nxt_o
);

    logic [SW-1:0] rq_prod;
    logic [SW-1:0] qr_prod;

    gf2m8_multi u_mul_rq (.a_i(msb_r_i), .b_i(q_prev_i), .p_o(rq_prod));
    gf2m8_multi u_mul_qr (.a_i(msb_q_i), .b_i(r_prev_i), .p_o(qr_prod));

    always_comb begin
        r_nxt_o = r_cur_i;
        q_nxt_o = q_cur_i;
        case (op_i)
            OP_SHIFT: begin
                q_nxt_o = q_prev_i;
            end
            OP_COMPUTE: begin
                r_nxt_o = rq_prod ^ qr_prod;
                if (swap_i) q_nxt_o = r_cur_i;
            end
            default: ;
        endcase
    end

endmodule

module gf2m8_multi
    import s2_kes_dcme_param_pkg::*;
(
    input  logic [SW-1:0] a_i,
    input  logic [SW-1:0] b_i,
    output logic [SW-1:0] p_o
);

    assign p_o = gf_mul(a_i, b_i);

endmodule

// File: rtl/s2_kes_dcme_param.sv
// DCME key-equation solver: 2T syndromes in, Lambda (T+1) and Omega (T) out,
// with start-edge detection, busy/done handshake, zero-syndrome bypass and fail flag.
module s2_kes_dcme_param
    import s2_kes_dcme_param_pkg::*;
#(
    parameter int unsigned T = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    s2_kes_dcme_param_if.slave      bus
);

    localparam int unsigned NW = 3 * T + 1;
    localparam int unsigned DW = $clog2(2 * T + 1) + 1;
    localparam int unsigned CW = $clog2(2 * T + 1);
    localparam logic [DW-1:0] DEG_T      = DW'(T);
    localparam logic [DW-1:0] DEG_R_INIT = DW'(2 * T);
    localparam logic [DW-1:0] DEG_Q_INIT = DW'(2 * T - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(2 * T - 1);

    kes_state_e             state_q;
    logic [CW-1:0]          cnt_q;
    logic                   kes_ena_1t_q;
    logic                   zs_q;
    logic [SW-1:0]          r_q [NW];
    logic [SW-1:0]          q_q [NW];
    logic [SW-1:0]          r_d [NW];
    logic [SW-1:0]          q_d [NW];
    logic [SW-1:0]          r_it [NW];
    logic [SW-1:0]          q_it [NW];
    logic [DW-1:0]          deg_r_q, deg_q_q, deg_r_d, deg_q_d;
    logic [SW*(T+1)-1:0]    lambda_q, lambda_fin;
    logic [SW*T-1:0]        omega_q, omega_fin;
    logic                   fail_q, fail_fin;
    logic                   done_q;
    logic                   busy_q;

    logic                   kes_init;
    logic                   load;
    logic [SW-1:0]          msb_r;
    logic [SW-1:0]          msb_q;
    logic                   swap;
    kes_op_e                op;

    assign kes_init = bus.kes_ena & ~kes_ena_1t_q;
    assign load     = kes_init & (state_q == ST_IDLE);
    assign msb_r    = r_q[NW-1];
    assign msb_q    = q_q[NW-1];
    assign swap     = (msb_r != '0) && (deg_r_q < deg_q_q);

    always_comb begin
        op = OP_HOLD;
        if (state_q == ST_ITER && deg_r_q >= DEG_T) begin
            op = (msb_q == '0) ? OP_SHIFT : OP_COMPUTE;
        end
    end

    // Word 0 has no lower neighbour: it only ever receives zero or a swapped R[0].
    assign r_it[0] = (op == OP_COMPUTE) ? '0 : r_q[0];
    assign q_it[0] = (op == OP_SHIFT)           ? '0      :
                     (op == OP_COMPUTE && swap) ? r_q[0]  : q_q[0];

    for (genvar k = 1; k < NW; k++) begin : g_pe
        s2_kes_dcme_param_pe u_pe (
            .op_i     (op),
            .swap_i   (swap),
            .msb_r_i  (msb_r),
            .msb_q_i  (msb_q),
            .r_prev_i (r_q[k-1]),
            .q_prev_i (q_q[k-1]),
            .r_cur_i  (r_q[k]),
            .q_cur_i  (q_q[k]),
            .r_nxt_o  (r_it[k]),
            .q_nxt_o  (q_it[k])
        );
    end

    always_comb begin
        r_d = r_it;
        q_d = q_it;
        if (load) begin
            for (int unsigned k = 0; k < NW; k++) begin
                r_d[k] = '0;
                q_d[k] = '0;
            end
            r_d[NW-1] = SW'(1);
            q_d[0]    = SW'(1);
            for (int unsigned i = 0; i < 2 * T; i++) begin
                q_d[T + 1 + i] = bus.rs_syn[syn_idx(i) +: SW];
            end
        end
    end

    always_comb begin
        deg_r_d = deg_r_q;
        deg_q_d = deg_q_q;
        if (load) begin
            deg_r_d = DEG_R_INIT;
            deg_q_d = DEG_Q_INIT;
        end else begin
            case (op)
                OP_SHIFT: deg_q_d = deg_q_q - 1'b1;
                OP_COMPUTE: begin
                    if (swap) begin
                        deg_r_d = deg_q_q - 1'b1;
                        deg_q_d = deg_r_q;
                    end else begin
                        deg_r_d = deg_r_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        lambda_fin = '0;
        omega_fin  = '0;
        if (zs_q) begin
            lambda_fin[coef_idx(0) +: SW] = SW'(1);
        end else begin
            for (int unsigned j = 0; j <= T; j++) begin
                lambda_fin[coef_idx(j) +: SW] = r_q[T + j];
            end
            for (int unsigned j = 0; j < T; j++) begin
                omega_fin[coef_idx(j) +: SW] = r_q[2 * T + 1 + j];
            end
        end
        fail_fin = ~zs_q & ((deg_r_q >= DEG_T) | (r_q[T] == '0));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            kes_ena_1t_q <= 1'b0;
            zs_q         <= 1'b0;
            deg_r_q      <= '0;
            deg_q_q      <= '0;
            for (int unsigned k = 0; k < NW; k++) begin
                r_q[k] <= '0;
                q_q[k] <= '0;
            end
            lambda_q     <= '0;
            omega_q      <= '0;
            fail_q       <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            kes_ena_1t_q <= bus.kes_ena;
            done_q       <= 1'b0;
            r_q          <= r_d;
            q_q          <= q_d;
            deg_r_q      <= deg_r_d;
            deg_q_q      <= deg_q_d;
            case (state_q)
                ST_IDLE: begin
                    if (kes_init) begin
                        state_q <= ST_ITER;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        zs_q    <= (bus.rs_syn == '0);
                    end
                end
                ST_ITER: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_q <= ST_FIN;
                end
                ST_FIN: begin
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    lambda_q <= lambda_fin;
                    omega_q  <= omega_fin;
                    fail_q   <= fail_fin;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.rs_lambda = lambda_q;
    assign bus.rs_omega  = omega_q;
    assign bus.kes_fail  = fail_q;
    assign bus.kes_done  = done_q;
    assign bus.kes_busy  = busy_q;

endmodule

// File: tb/tb_s2_kes_dcme_param.sv
// Directed bench for s2_kes_dcme_param at T=2: hand-derived Lambda/Omega vectors,
// handshake timing masks and reset behaviour.
module tb_s2_kes_dcme_param;

    localparam int unsigned T    = 2;
    localparam int unsigned SYNW = 8 * 2 * T;

    // Syndromes packed S3..S0; results packed L2..L0 and O1..O0.
    localparam logic [SYNW-1:0] SYN_ZERO = 32'h00_00_00_00;
    localparam logic [SYNW-1:0] SYN_ONE  = 32'h01_01_01_01;
    localparam logic [SYNW-1:0] SYN_TWO  = 32'h09_05_03_00;
    localparam logic [SYNW-1:0] SYN_SHFT = 32'h00_00_00_01;
    localparam logic [SYNW-1:0] SYN_L0Z  = 32'h01_00_00_00;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    s2_kes_dcme_param_if #(.T(T)) bus ();

    s2_kes_dcme_param #(.T(T)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drives kes_ena from a per-cycle mask; bit c of the masks is the value seen in cycle c.
    task automatic run_pattern(input logic [SYNW-1:0] syn, input logic [31:0] ena_mask,
                               input int unsigned ncyc,
                               output logic [31:0] done_mask, output logic [31:0] busy_mask);
        done_mask = '0;
        busy_mask = '0;
        for (int unsigned c = 0; c < ncyc; c++) begin
            bus.kes_ena = ena_mask[c];
            bus.rs_syn  = syn;
            @(posedge clk);
            #1;
            done_mask[c + 1] = bus.kes_done;
            busy_mask[c + 1] = bus.kes_busy;
        end
        bus.kes_ena = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [31:0] lam,
                                input logic [31:0] om, input logic fail);
        check({tag, "_lambda"}, 32'(bus.rs_lambda), lam);
        check({tag, "_omega"},  32'(bus.rs_omega),  om);
        check({tag, "_fail"},   32'(bus.kes_fail),  32'(fail));
    endtask

    task automatic decode(input string tag, input logic [SYNW-1:0] syn,
                          input logic [31:0] lam, input logic [31:0] om, input logic fail);
        logic [31:0] dm, bm;
        run_pattern(syn, 32'h1, 10, dm, bm);
        check({tag, "_done_mask"}, dm, 32'h40);
        check({tag, "_busy_mask"}, bm, 32'h3E);
        check_result(tag, lam, om, fail);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] dm, bm;

        bus.kes_ena = 1'b0;
        bus.rs_syn  = '0;
        rstn        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_result("reset", 32'h0, 32'h0, 1'b0);
        check("reset_busy", 32'(bus.kes_busy), 32'h0);
        check("reset_done", 32'(bus.kes_done), 32'h0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        decode("single", SYN_ONE,  32'h00_01_01, 32'h00_01, 1'b0);
        decode("two",    SYN_TWO,  32'hB0_E8_58, 32'hE8_00, 1'b0);
        decode("zero",   SYN_ZERO, 32'h00_00_01, 32'h00_00, 1'b0);
        decode("shift",  SYN_SHFT, 32'h01_00_00, 32'h00_00, 1'b1);

        // Second edge in cycle 3 while busy, ena still high through the done cycle.
        run_pattern(SYN_ONE, 32'h1F9, 14, dm, bm);
        check("hs_ignore_done_mask", dm, 32'h40);
        check("hs_ignore_busy_mask", bm, 32'h3E);
        check_result("hs_ignore", 32'h00_01_01, 32'h00_01, 1'b0);

        // New edge coinciding with the done pulse is accepted.
        run_pattern(SYN_TWO, 32'h41, 16, dm, bm);
        check("hs_b2b_done_mask", dm, 32'h1040);
        check("hs_b2b_busy_mask", bm, 32'hFBE);
        check_result("hs_b2b", 32'hB0_E8_58, 32'hE8_00, 1'b0);

        decode("lam0zero", SYN_L0Z, 32'h00_01_00, 32'h00_00, 1'b1);

        // Reset in cycle 3 of a decode.
        bus.rs_syn  = SYN_TWO;
        bus.kes_ena = 1'b1;
        @(posedge clk); #1;
        bus.kes_ena = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        check_result("midrst", 32'h0, 32'h0, 1'b0);
        check("midrst_busy", 32'(bus.kes_busy), 32'h0);
        check("midrst_done", 32'(bus.kes_done), 32'h0);
        rstn = 1'b1;
        run_pattern(SYN_TWO, 32'h0, 12, dm, bm);
        check("midrst_no_done", dm, 32'h0);
        check("midrst_no_busy", bm, 32'h0);

        // kes_ena held high across reset release restarts the block.
        bus.rs_syn  = SYN_ONE;
        bus.kes_ena = 1'b1;
        rstn        = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        run_pattern(SYN_ONE, 32'h3, 10, dm, bm);
        check("held_ena_done_mask", dm, 32'h40);
        check("held_ena_busy_mask", bm, 32'h3E);
        check_result("held_ena", 32'h00_01_01, 32'h00_01, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
